// File: rtl/dcache_port_arb_if.sv
// Request/response bundle shared by the two requester ports and the dcache
// side of dcache_port_arb. The requester (or the arbiter, toward the dcache)
// is the master; the responder is the slave.
interface dcache_port_arb_if;
  logic        req;
  logic        op;       // 1 = store
  logic [2:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, op, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, op, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/dcache_port_arb.sv
// Two-port data-cache arbiter. Port 0 is the pipeline requester, port 1 the
// page-walk/refill requester. Requests are passed through combinationally;
// an in-order tag FIFO remembers which port owns each outstanding response,
// and flush marks pending port-0 responses as killed.
// Optional starvation guard for port 1: define DCACHE_ARB_STARVE_GUARD_EN.
module dcache_port_arb #(
  parameter int STARVE_LIMIT = 4,
  parameter int OST_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                resetn,
  dcache_port_arb_if.slave    p0,
  dcache_port_arb_if.slave    p1,
  dcache_port_arb_if.master   dc,
  input  logic                flush,
  output logic                busy
);

  localparam int PTR_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
  localparam int CNT_W = $clog2(OST_DEPTH) + 1;

  typedef enum logic [1:0] {
    ARB_FREE,
    ARB_LOCK_P0,
    ARB_LOCK_P1
  } arb_state_t;

  arb_state_t       state_q, state_d;
  logic             run_q;
  logic             grant_p1;
  logic             p0_eff;
  logic             dc_req;
  logic             push, pop;
  logic             full;
  logic             starve_promote;
  logic             head_port, head_kill;
  logic             p0_deliver, p1_deliver;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             tag_port [OST_DEPTH];
  logic             tag_kill [OST_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OST_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Output enable: holds every request/response output low from reset
  // assertion until the first clock after release, without routing the
  // asynchronous reset through combinational logic.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  assign p0_eff = p0.req & ~flush;
  assign full   = (count == CNT_W'(OST_DEPTH));
  assign dc_req = run_q & ~full & (p0_eff | p1.req);
  assign push   = dc_req & dc.addr_ok;
  assign pop    = dc.data_ok & (count != '0);
  assign busy   = (count != '0);

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  logic [STV_W-1:0] starve_cnt;
  logic             p1_win;

  assign p1_win         = dc_req & grant_p1;
  assign starve_promote = (starve_cnt == STV_W'(STARVE_LIMIT));

  // Counts cycles port 1 asks but loses; clears once port 1 is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (p1_win && dc.addr_ok) begin
      starve_cnt <= '0;
    end else if (p1.req && !p1_win && !starve_promote) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_promote = 1'b0;
`endif

  // Grant lock state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ARB_FREE;
    else         state_q <= state_d;
  end

  // Grant selection and next lock state.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant_p1 = 1'b0;
    state_d  = ARB_FREE;
    unique case (state_q)
      ARB_LOCK_P0: grant_p1 = ~p0_eff & (starve_promote ? p1.req : p1.req);
      ARB_LOCK_P1: grant_p1 = p1.req | ~p0_eff;
      default:     grant_p1 = starve_promote ? p1.req : ~p0_eff;
    endcase
    // A lock whose owner dropped its request falls back to normal priority.
    if ((state_q == ARB_LOCK_P0 && !p0_eff) || (state_q == ARB_LOCK_P1 && !p1.req)) begin
      grant_p1 = (starve_promote && p1.req) ? 1'b1 : ~p0_eff;
    end
    if (dc_req && !dc.addr_ok) begin
      state_d = grant_p1 ? ARB_LOCK_P1 : ARB_LOCK_P0;
    end
  end

  // Request payload mux; zero whenever no request is presented.
  always_comb begin
    dc.req   = dc_req;
    dc.op    = 1'b0;
    dc.size  = '0;
    dc.wstrb = '0;
    dc.addr  = '0;
    dc.wdata = '0;
    if (dc_req) begin
      dc.op    = grant_p1 ? p1.op    : p0.op;
      dc.size  = grant_p1 ? p1.size  : p0.size;
      dc.wstrb = grant_p1 ? p1.wstrb : p0.wstrb;
      dc.addr  = grant_p1 ? p1.addr  : p0.addr;
      dc.wdata = grant_p1 ? p1.wdata : p0.wdata;
    end
  end

  assign p0.addr_ok = dc.addr_ok & dc_req & ~grant_p1;
  assign p1.addr_ok = dc.addr_ok & dc_req &  grant_p1;

  // Response routing from the head tag.
  assign head_port  = tag_port[rd_ptr];
  assign head_kill  = tag_kill[rd_ptr];
  assign p0_deliver = run_q & pop & ~head_kill & ~head_port & ~flush;
  assign p1_deliver = run_q & pop & ~head_kill &  head_port;
  assign p0.data_ok = p0_deliver;
  assign p1.data_ok = p1_deliver;
  assign p0.rdata   = p0_deliver ? dc.rdata : '0;
  assign p1.rdata   = p1_deliver ? dc.rdata : '0;

  // Outstanding-tag FIFO: push on acceptance, pop on each response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the tag storage is reset too; kill bits left over from before a
      // reset must never suppress a response belonging to a new request.
      for (int i = 0; i < OST_DEPTH; i++) begin
        tag_port[i] <= 1'b0;
        tag_kill[i] <= 1'b0;
      end
    end else begin
      // Killing free slots as well is harmless: a push rewrites the kill bit.
      if (flush) begin
        for (int i = 0; i < OST_DEPTH; i++) begin
          if (!tag_port[i]) tag_kill[i] <= 1'b1;
        end
      end
      if (push) begin
        tag_port[wr_ptr] <= grant_p1;
        tag_kill[wr_ptr] <= 1'b0;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
